// File: rtl/pres_sel_gen.sv
// pres_sel_gen: prescaled channel-select sequencer.
//
// A programmable prescaler counts enabled cycles. Each time the count
// reaches the divisor, the select index advances according to the mode.
// One advance every div_r+1 enabled cycles.
//
// Modes: UP, DOWN, BOUNCE (ping-pong without repeating endpoints), HOLD.
//
// Ports:
//   CLK      rising-edge clock
//   RST      synchronous active-high reset
//   en       prescaler run enable
//   load     single-cycle strobe; captures div_in/mode_in and restarts the count
//   div_in   new divisor (period = div_in+1 enabled cycles)
//   mode_in  new mode: 0 UP, 1 DOWN, 2 BOUNCE, 3 HOLD
//   sel      registered binary channel index, always in 0..NCH-1
//   sel_oh   registered one-hot decode of sel
//   tick     one-cycle pulse in the cycle sel takes its new value
//   wrap     one-cycle pulse with tick when the sequence wraps
module pres_sel_gen #(
    parameter int NCH      = 2,
    parameter int DIVW     = 8,
    parameter int DIV_INIT = 0,
    localparam int SELW    = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            en,
    input  logic            load,
    input  logic [DIVW-1:0] div_in,
    input  logic [1:0]      mode_in,
    output logic [SELW-1:0] sel,
    output logic [NCH-1:0]  sel_oh,
    output logic            tick,
    output logic            wrap
);

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_t;

    localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);
    localparam logic [SELW-1:0] ONE_S = SELW'(1);
    localparam logic [DIVW-1:0] ONE_D = DIVW'(1);

    logic [DIVW-1:0] cnt, cnt_nxt;
    logic [DIVW-1:0] div_r, div_nxt;
    mode_t           mode_r, mode_nxt;
    logic            dir_dn, dir_nxt;   // BOUNCE direction: 1 = moving down
    logic [SELW-1:0] sel_nxt;
    logic            tick_nxt, wrap_nxt;
    logic            go_up;

    function automatic logic [NCH-1:0] decode(input logic [SELW-1:0] s);
        logic [NCH-1:0] oh;
        oh = '0;
        for (int i = 0; i < NCH; i++) begin
            if (s == SELW'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    always_comb begin
        cnt_nxt  = cnt;
        div_nxt  = div_r;
        mode_nxt = mode_r;
        dir_nxt  = dir_dn;
        sel_nxt  = sel;
        tick_nxt = 1'b0;
        wrap_nxt = 1'b0;
        go_up    = 1'b0;

        if (load) begin
            // load takes priority over a pending advance and restarts the count
            div_nxt  = div_in;
            mode_nxt = mode_t'(mode_in);
            cnt_nxt  = '0;
            if (mode_t'(mode_in) == MODE_BOUNCE) dir_nxt = 1'b0;
        end else if (en) begin
            if (cnt == div_r) begin
                cnt_nxt  = '0;
                tick_nxt = 1'b1;
                case (mode_r)
                    MODE_UP: begin
                        if (sel == LAST) begin
                            sel_nxt  = '0;
                            wrap_nxt = 1'b1;
                        end else begin
                            sel_nxt = sel + ONE_S;
                        end
                    end
                    MODE_DOWN: begin
                        if (sel == '0) begin
                            sel_nxt  = LAST;
                            wrap_nxt = 1'b1;
                        end else begin
                            sel_nxt = sel - ONE_S;
                        end
                    end
                    MODE_BOUNCE: begin
                        // Endpoints force the direction so that entering BOUNCE
                        // at NCH-1 (dir reset to up) still turns around cleanly.
                        go_up = (sel == '0) || (!dir_dn && (sel != LAST));
                        if (go_up) begin
                            sel_nxt = sel + ONE_S;
                        end else begin
                            sel_nxt  = sel - ONE_S;
                            wrap_nxt = (sel == ONE_S);
                        end
                        if (sel_nxt == LAST)     dir_nxt = 1'b1;
                        else if (sel_nxt == '0)  dir_nxt = 1'b0;
                        else                     dir_nxt = !go_up;
                    end
                    default: begin
                        // HOLD: tick only, sel and dir unchanged
                    end
                endcase
            end else begin
                cnt_nxt = cnt + ONE_D;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt    <= '0;
            div_r  <= DIVW'(DIV_INIT);
            mode_r <= MODE_UP;
            dir_dn <= 1'b0;
            sel    <= '0;
            sel_oh <= NCH'(1);
            tick   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            div_r  <= div_nxt;
            mode_r <= mode_nxt;
            dir_dn <= dir_nxt;
            sel    <= sel_nxt;
            sel_oh <= decode(sel_nxt);
            tick   <= tick_nxt;
            wrap   <= wrap_nxt;
        end
    end

endmodule
